// File: rtl/masked_shfrot_sequencer_if.sv
// rtl/masked_shfrot_sequencer_if.sv - request, shifter and response bundle for the masked shift/rotate sequencer
// Master is the environment (requester, shifter, response sink); slave is the sequencer.

interface masked_shfrot_sequencer_if #(
    parameter int BIT_WIDTH = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_op;
    logic [4:0]           req_shamt;
    logic [BIT_WIDTH-1:0] req_s0;
    logic [BIT_WIDTH-1:0] req_s1;
    logic [BIT_WIDTH-1:0] req_rp;
    logic [BIT_WIDTH-1:0] req_mask;

    logic                 sh_ena;
    logic                 sh_srli;
    logic                 sh_slli;
    logic                 sh_rori;
    logic [4:0]           sh_shamt;
    logic [BIT_WIDTH-1:0] sh_s0;
    logic [BIT_WIDTH-1:0] sh_s1;
    logic [BIT_WIDTH-1:0] sh_rp0;
    logic [BIT_WIDTH-1:0] sh_r0;
    logic [BIT_WIDTH-1:0] sh_r1;
    logic                 sh_ready;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [BIT_WIDTH-1:0] rsp_r0;
    logic [BIT_WIDTH-1:0] rsp_r1;
    logic                 rsp_err;

    modport master (
        output req_valid, req_op, req_shamt, req_s0, req_s1, req_rp, req_mask,
        input  req_ready,
        input  sh_ena, sh_srli, sh_slli, sh_rori, sh_shamt, sh_s0, sh_s1, sh_rp0,
        output sh_r0, sh_r1, sh_ready,
        input  rsp_valid, rsp_r0, rsp_r1, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_op, req_shamt, req_s0, req_s1, req_rp, req_mask,
        output req_ready,
        output sh_ena, sh_srli, sh_slli, sh_rori, sh_shamt, sh_s0, sh_s1, sh_rp0,
        input  sh_r0, sh_r1, sh_ready,
        output rsp_valid, rsp_r0, rsp_r1, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/masked_shfrot_sequencer.sv
// rtl/masked_shfrot_sequencer.sv - sequences one masked shift/rotate through an external shifter
// Shares are never recombined here; each result share is refreshed with the captured mask.

module masked_shfrot_sequencer #(
    parameter int BIT_WIDTH = 32,
    parameter int TIMEOUT   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    masked_shfrot_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_SRLI    = 2'b00;
    localparam logic [1:0] OP_SLLI    = 2'b01;
    localparam logic [1:0] OP_RORI    = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;
    localparam logic [3:0] WAIT_LAST  = 4'(TIMEOUT - 1);

    state_t               state_q;
    logic [1:0]           op_q;
    logic [4:0]           shamt_q;
    logic [BIT_WIDTH-1:0] s0_q;
    logic [BIT_WIDTH-1:0] s1_q;
    logic [BIT_WIDTH-1:0] rp_q;
    logic [BIT_WIDTH-1:0] mask_q;
    logic [BIT_WIDTH-1:0] r0_q;
    logic [BIT_WIDTH-1:0] r1_q;
    logic                 err_q;
    logic                 valid_q;
    logic                 ena_q;
    logic                 act_q;
    logic [3:0]           cnt_q;

    logic [BIT_WIDTH-1:0] r0_d;
    logic [BIT_WIDTH-1:0] r1_d;

    // Each share is refreshed independently so the unmasked value never exists on a wire.
    assign r0_d = bus.sh_r0 ^ mask_q;
    assign r1_d = bus.sh_r1 ^ mask_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            shamt_q <= '0;
            s0_q    <= '0;
            s1_q    <= '0;
            rp_q    <= '0;
            mask_q  <= '0;
            r0_q    <= '0;
            r1_q    <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ena_q   <= 1'b0;
            act_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q    <= bus.req_op;
                        shamt_q <= bus.req_shamt;
                        s0_q    <= bus.req_s0;
                        s1_q    <= bus.req_s1;
                        rp_q    <= bus.req_rp;
                        mask_q  <= bus.req_mask;
                        cnt_q   <= '0;
                        if (bus.req_op == OP_ILLEGAL) begin
                            state_q <= DONE;
                            valid_q <= 1'b1;
                            err_q   <= 1'b1;
                            r0_q    <= '0;
                            r1_q    <= '0;
                        end else begin
                            state_q <= ISSUE;
                            ena_q   <= 1'b1;
                            act_q   <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    ena_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.sh_ready) begin
                        r0_q    <= r0_d;
                        r1_q    <= r1_d;
                        err_q   <= 1'b0;
                        valid_q <= 1'b1;
                        act_q   <= 1'b0;
                        state_q <= DONE;
                    end else if (cnt_q == WAIT_LAST) begin
                        // Shifter never answered: report an error with zeroed shares.
                        r0_q    <= '0;
                        r1_q    <= '0;
                        err_q   <= 1'b1;
                        valid_q <= 1'b1;
                        act_q   <= 1'b0;
                        cnt_q   <= cnt_q + 4'd1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        valid_q <= 1'b0;
                        r0_q    <= '0;
                        r1_q    <= '0;
                        err_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE) && !rst;

    assign bus.sh_ena   = ena_q;
    assign bus.sh_srli  = act_q && (op_q == OP_SRLI);
    assign bus.sh_slli  = act_q && (op_q == OP_SLLI);
    assign bus.sh_rori  = act_q && (op_q == OP_RORI);
    assign bus.sh_shamt = act_q ? shamt_q : '0;
    assign bus.sh_s0    = act_q ? s0_q    : '0;
    assign bus.sh_s1    = act_q ? s1_q    : '0;
    assign bus.sh_rp0   = act_q ? rp_q    : '0;

    assign bus.rsp_valid = valid_q;
    assign bus.rsp_r0    = r0_q;
    assign bus.rsp_r1    = r1_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_masked_shfrot_sequencer.sv
// tb/tb_masked_shfrot_sequencer.sv - scoreboard bench for masked_shfrot_sequencer with a behavioural shifter stub

module tb_masked_shfrot_sequencer;
    localparam int W  = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    masked_shfrot_sequencer_if #(.BIT_WIDTH(W)) bus ();

    masked_shfrot_sequencer #(.BIT_WIDTH(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] r0;
        logic [W-1:0] r1;
        logic [W-1:0] x;
        logic         err;
        int           lat;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    int           stub_delay = 0;
    int           stub_d = 0;
    int           rdy_mode = 0;
    int           legal_cnt = 0;
    int           ena_pulses = 0;
    int           ena_run = 0;
    logic [1:0]   cur_op = '0;
    logic [4:0]   cur_sh = '0;
    logic [W-1:0] cur_s0 = '0, cur_s1 = '0, cur_rp = '0;
    logic [1:0]   stub_op;
    logic [W-1:0] stub_r0, stub_r1;
    logic         pv = 1'b0, pr = 1'b0, pe = 1'b0;
    logic [W-1:0] p0 = '0, p1 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] shf(input logic [1:0] op, input logic [W-1:0] x, input logic [4:0] s);
        logic [2*W-1:0] dbl;
        dbl = {x, x} >> s;
        case (op)
            2'd0:    return x >> s;
            2'd1:    return x << s;
            default: return dbl[W-1:0];
        endcase
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] op);
        return 3'b001 << op;
    endfunction

    // Shifter stub: answers per share after stub_delay cycles (0 = never), padding folded into both shares.
    initial begin
        bus.sh_ready = 1'b0;
        bus.sh_r0    = '0;
        bus.sh_r1    = '0;
        forever begin
            @(negedge clk);
            if (bus.sh_ena === 1'b1 && !rst) begin
                stub_d  = stub_delay;
                stub_op = bus.sh_rori ? 2'd2 : (bus.sh_slli ? 2'd1 : 2'd0);
                stub_r0 = shf(stub_op, bus.sh_s0, bus.sh_shamt) ^ bus.sh_rp0;
                stub_r1 = shf(stub_op, bus.sh_s1, bus.sh_shamt) ^ bus.sh_rp0;
                if (stub_d > 0) begin
                    repeat (stub_d) @(posedge clk);
                    #1;
                    bus.sh_ready = 1'b1;
                    bus.sh_r0    = stub_r0;
                    bus.sh_r1    = stub_r1;
                    @(posedge clk);
                    #1;
                    bus.sh_ready = 1'b0;
                    bus.sh_r0    = $urandom;
                    bus.sh_r1    = $urandom;
                end
            end
        end
    end

    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.rsp_ready = ($urandom_range(0, 2) != 0);
                1:       bus.rsp_ready = 1'b0;
                default: bus.rsp_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on the first rsp_valid cycle, then checks hold and release behaviour.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                pr = 1'b0;
                ena_run = 0;
            end else begin
                if (bus.sh_ena) begin
                    ena_run++;
                    if (ena_run == 1) begin
                        ena_pulses++;
                        chk("sh_onehot", W'({bus.sh_rori, bus.sh_slli, bus.sh_srli}), W'(onehot(cur_op)));
                        chk("sh_shamt", W'(bus.sh_shamt), W'(cur_sh));
                        chk("sh_s0", bus.sh_s0, cur_s0);
                        chk("sh_s1", bus.sh_s1, cur_s1);
                        chk("sh_rp0", bus.sh_rp0, cur_rp);
                    end
                end else if (ena_run > 0) begin
                    chk("sh_ena_width", W'(ena_run), W'(1));
                    ena_run = 0;
                end
                if (pv && pr) begin
                    chk("req_ready_after_rsp", W'(bus.req_ready), W'(1));
                    chk("rsp_cleared", W'(bus.rsp_valid) | bus.rsp_r0 | bus.rsp_r1, '0);
                end
                if (bus.rsp_valid) begin
                    chk("req_ready_in_done", W'(bus.req_ready), W'(0));
                    chk("sh_idle_in_done", bus.sh_s0 | bus.sh_s1 | bus.sh_rp0 |
                        W'({bus.sh_ena, bus.sh_srli, bus.sh_slli, bus.sh_rori}), '0);
                    if (!pv) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_rsp actual=valid expected=none");
                        end else begin
                            mon_e = exp_q.pop_front();
                            chk("rsp_r0", bus.rsp_r0, mon_e.r0);
                            chk("rsp_r1", bus.rsp_r1, mon_e.r1);
                            chk("rsp_unmasked", bus.rsp_r0 ^ bus.rsp_r1, mon_e.x);
                            chk("rsp_err", W'(bus.rsp_err), W'(mon_e.err));
                            chk("rsp_latency", W'(cyc - acc_cyc), W'(mon_e.lat));
                        end
                    end else if (!pr) begin
                        chk("hold_r0", bus.rsp_r0, p0);
                        chk("hold_r1", bus.rsp_r1, p1);
                        chk("hold_err", W'(bus.rsp_err), W'(pe));
                    end
                end else if (pv && !pr) begin
                    chk("rsp_held", W'(bus.rsp_valid), W'(1));
                end
                pv = bus.rsp_valid;
                pr = bus.rsp_ready;
                pe = bus.rsp_err;
                p0 = bus.rsp_r0;
                p1 = bus.rsp_r1;
            end
        end
    end

    task automatic wait_accept();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready) begin
            n++;
            if (n > 200) begin
                $display("FAIL accept_timeout actual=no_req_ready expected=req_ready");
                $fatal(1, "request never accepted");
            end
            @(negedge clk);
        end
        acc_cyc = cyc + 1;
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [4:0] sh, input logic [W-1:0] s0,
                             input logic [W-1:0] s1, input logic [W-1:0] rp, input logic [W-1:0] mask);
        bus.req_op    = op;
        bus.req_shamt = sh;
        bus.req_s0    = s0;
        bus.req_s1    = s1;
        bus.req_rp    = rp;
        bus.req_mask  = mask;
        bus.req_valid = 1'b1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] sh, input logic [W-1:0] s0,
                         input logic [W-1:0] s1, input logic [W-1:0] rp, input logic [W-1:0] mask,
                         input int d, input logic [W-1:0] xexp, input bit use_x);
        exp_t e;
        bit   legal;
        bit   ok;
        legal = (op != 2'b11);
        ok    = legal && d >= 1 && d <= TO;
        e.err = !ok;
        e.r0  = ok ? (shf(op, s0, sh) ^ rp ^ mask) : '0;
        e.r1  = ok ? (shf(op, s1, sh) ^ rp ^ mask) : '0;
        e.x   = ok ? (use_x ? xexp : shf(op, s0 ^ s1, sh)) : '0;
        e.lat = !legal ? 0 : (ok ? 1 + d : 1 + TO);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        stub_delay = d;
        cur_op = op;
        cur_sh = sh;
        cur_s0 = s0;
        cur_s1 = s1;
        cur_rp = rp;
        if (legal) legal_cnt++;
        drive_req(op, sh, s0, s1, rp, mask);
        wait_accept();
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_s0    = $urandom;
        bus.req_s1    = $urandom;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d expected=0 pending responses", exp_q.size());
        end
    endtask

    logic [W-1:0] a, b;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_shamt = '0;
        bus.req_s0    = '0;
        bus.req_s1    = '0;
        bus.req_rp    = '0;
        bus.req_mask  = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_req_ready", W'(bus.req_ready), W'(0));
        chk("reset_outputs", W'({bus.rsp_valid, bus.sh_ena, bus.rsp_err}) | bus.rsp_r0 | bus.sh_s0, '0);
        rst = 1'b0;
        #1;
        chk("release_req_ready", W'(bus.req_ready), W'(1));

        issue(2'd0, 5'd4, 32'hF0F0F0F0, 32'h0F0F0F0F, $urandom, 32'hA5A5A5A5, 1, 32'h0FFFFFFF, 1'b1);
        a = $urandom;
        issue(2'd2, 5'd8, a, a ^ 32'h12345678, $urandom, $urandom, 1, 32'h78123456, 1'b1);
        issue(2'd3, 5'($urandom), $urandom, $urandom, $urandom, $urandom, 1, '0, 1'b0);
        issue(2'd1, 5'($urandom), $urandom, $urandom, $urandom, $urandom, 0, '0, 1'b0);
        drain();

        rdy_mode = 1;
        issue(2'd1, 5'd3, $urandom, $urandom, $urandom, $urandom, 2, '0, 1'b0);
        while (!bus.rsp_valid) @(negedge clk);
        repeat (3) @(negedge clk);
        rdy_mode = 2;
        drain();
        rdy_mode = 0;

        // Abort in WAIT via asynchronous reset; the shifter stub never answers this one.
        a = $urandom | 32'h1;
        b = $urandom | 32'h1;
        @(posedge clk);
        #1;
        stub_delay = 0;
        cur_op = 2'd0;
        cur_sh = 5'd7;
        cur_s0 = a;
        cur_s1 = b;
        cur_rp = a ^ b;
        legal_cnt++;
        drive_req(2'd0, 5'd7, a, b, a ^ b, $urandom);
        wait_accept();
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #3;
        chk("wait_sh_s0", bus.sh_s0, a);
        rst = 1'b1;
        #1;
        chk("abort_sh_ena", W'({bus.sh_ena, bus.rsp_valid, bus.req_ready}), '0);
        chk("abort_operands", bus.sh_s0 | bus.sh_s1 | bus.sh_rp0 | W'(bus.sh_shamt) |
            W'({bus.sh_srli, bus.sh_slli, bus.sh_rori}), '0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("abort_release_ready", W'(bus.req_ready), W'(1));
        issue(2'd2, 5'd13, $urandom, $urandom, $urandom, $urandom, 1, '0, 1'b0);
        drain();

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), 5'($urandom), $urandom, $urandom, $urandom, $urandom,
                  $urandom_range(0, TO + 2), '0, 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        drain();
        repeat (4) @(negedge clk);
        chk("sh_ena_pulse_count", W'(ena_pulses), W'(legal_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/masked_shfrot_sequencer.md
MASKED_SHFROT_SEQUENCER -- requirements
Module: masked_shfrot_sequencer

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, share width.
REQ-002 SHALL have parameter TIMEOUT, default 4, maximum WAIT cycles before error (range 1..15).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1 / req_ready  output  1  request handshake.
REQ-006 req_op  input  2  operation: 00 srli, 01 slli, 10 rori, 11 illegal.
REQ-007 req_shamt  input  5  shift amount.
REQ-008 req_s0, req_s1  input  BIT_WIDTH  operand shares.
REQ-009 req_rp  input  BIT_WIDTH  random padding for the shifter.
REQ-010 req_mask  input  BIT_WIDTH  fresh randomness for output refresh.
REQ-011 sh_ena, sh_srli, sh_slli, sh_rori  output  1  shifter controls.
REQ-012 sh_shamt  output  5 / sh_s0, sh_s1, sh_rp0  output  BIT_WIDTH  shifter operands.
REQ-013 sh_r0, sh_r1  input  BIT_WIDTH / sh_ready  input  1  shifter result and completion.
REQ-014 rsp_valid  output  1 / rsp_ready  input  1  response handshake.
REQ-015 rsp_r0, rsp_r1  output  BIT_WIDTH  refreshed result shares; rsp_err  output  1  error flag.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; state, operand, result and counter registers SHALL all be registered.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid&req_ready; all req_* fields SHALL be captured on that edge.
REQ-018 On accept, legal op: IDLE->ISSUE; illegal op (11): IDLE->DONE with rsp_err=1, rsp_r0=rsp_r1=0, no shifter activity.
REQ-019 sh_ena SHALL be 1 for exactly the single ISSUE cycle; ISSUE->WAIT unconditionally.
REQ-020 sh_srli/sh_slli/sh_rori SHALL be one-hot decoded from the captured op; these and sh_shamt, sh_s0, sh_s1, sh_rp0 SHALL be driven from captured registers in ISSUE and WAIT, and SHALL be all-zero in IDLE and DONE.
REQ-021 In WAIT with sh_ready=1: rsp_r0<=sh_r0^mask, rsp_r1<=sh_r1^mask, rsp_err<=0, ->DONE; sh_r0/sh_r1 SHALL be sampled only in that cycle.
REQ-022 WAIT counter SHALL clear on ISSUE entry and increment each WAIT cycle without sh_ready; after TIMEOUT such cycles: ->DONE, rsp_err=1, rsp_r0=rsp_r1=0.
REQ-023 rsp_valid SHALL be 1 exactly in DONE; rsp_r0, rsp_r1, rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-024 DONE with rsp_ready=1: ->IDLE, rsp_r0/rsp_r1 cleared to 0 on that edge; new request acceptable from the next cycle.
REQ-025 sh_ready outside WAIT SHALL be ignored.
REQ-026 Latency, legal op, shifter ready one cycle after sh_ena: accept edge k, ISSUE cycle k+1, WAIT k+2, rsp_valid from cycle k+3.
REQ-027 Unmasked operand (share XOR) SHALL never be formed; each output share combines only its own shifter share with req_mask.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, counter 0, and all outputs 0 except req_ready.
REQ-029 req_ready SHALL be 0 while rst=1 and 1 on the first cycle after release.
REQ-030 Reset asserted mid-operation (ISSUE/WAIT/DONE) SHALL abort the operation, deassert sh_ena asynchronously, and discard any pending response.

Verification
REQ-031 srli, shamt=4, s0=0xF0F0F0F0, s1=0x0F0F0F0F, mask=0xA5A5A5A5, real shifter attached -> rsp_valid at k+3, rsp_r0^rsp_r1=0x0FFFFFFF, rsp_r0=sh_r0^0xA5A5A5A5, rsp_err=0.
REQ-032 rori, shamt=8, shares XOR to 0x12345678 -> rsp_r0^rsp_r1=0x78123456; sh_rori=1 and sh_ena high exactly one cycle.
REQ-033 req_op=11 -> rsp_valid at k+1, rsp_err=1, rsp_r0=rsp_r1=0, sh_ena never asserted.
REQ-034 Stubbed sh_ready tied 0, TIMEOUT=4 -> 4 WAIT cycles then rsp_valid=1, rsp_err=1, shares 0.
REQ-035 rsp_ready held 0 for 3 cycles after rsp_valid -> outputs stable, req_ready=0 throughout; handshake then IDLE with req_ready=1 next cycle.
REQ-036 rst pulsed during WAIT -> sh_ena=0, rsp_valid=0, all shifter operands 0 immediately; next request completes normally.
